// File: rtl/audio_pkg.sv
// Shared audio-block definitions: increment/note widths and the
// increment-to-note converter state encoding.
package audio_pkg;

    localparam int SAMPLE_RATE = 31250;
    localparam int NOTE_COUNT  = 128;
    localparam int NOTE_W      = $clog2(NOTE_COUNT);
    localparam int INC_W       = 16;

    localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'(NOTE_COUNT - 1);
    localparam logic [2:0]        TOP_BIT  = 3'(NOTE_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CMP   = 3'd2,
        ST_NADDR = 3'd3,
        ST_NCMP  = 3'd4,
        ST_DONE  = 3'd5
    } inc2note_state_e;

endpackage

// File: rtl/midi_note_table_rom.sv
// Note-to-increment table, round(440*2^((n-69)/12)*65536/31250), as a
// dual-read synchronous ROM with one cycle of read latency on each port.
module midi_note_table_rom
    import audio_pkg::*;
(
    input  logic              clk_i,
    input  logic [NOTE_W-1:0] addr_a_i,
    input  logic [NOTE_W-1:0] addr_b_i,
    output logic [INC_W-1:0]  data_a_o,
    output logic [INC_W-1:0]  data_b_o
);

    logic [INC_W-1:0] data_a_q;
    logic [INC_W-1:0] data_b_q;

    function automatic logic [INC_W-1:0] note_inc(input logic [NOTE_W-1:0] note);
        logic [INC_W-1:0] v;
        case (note)
            7'd0:   v = 16'd17;    7'd1:   v = 16'd18;    7'd2:   v = 16'd19;    7'd3:   v = 16'd20;
            7'd4:   v = 16'd22;    7'd5:   v = 16'd23;    7'd6:   v = 16'd24;    7'd7:   v = 16'd26;
            7'd8:   v = 16'd27;    7'd9:   v = 16'd29;    7'd10:  v = 16'd31;    7'd11:  v = 16'd32;
            7'd12:  v = 16'd34;    7'd13:  v = 16'd36;    7'd14:  v = 16'd38;    7'd15:  v = 16'd41;
            7'd16:  v = 16'd43;    7'd17:  v = 16'd46;    7'd18:  v = 16'd48;    7'd19:  v = 16'd51;
            7'd20:  v = 16'd54;    7'd21:  v = 16'd58;    7'd22:  v = 16'd61;    7'd23:  v = 16'd65;
            7'd24:  v = 16'd69;    7'd25:  v = 16'd73;    7'd26:  v = 16'd77;    7'd27:  v = 16'd82;
            7'd28:  v = 16'd86;    7'd29:  v = 16'd92;    7'd30:  v = 16'd97;    7'd31:  v = 16'd103;
            7'd32:  v = 16'd109;   7'd33:  v = 16'd115;   7'd34:  v = 16'd122;   7'd35:  v = 16'd129;
            7'd36:  v = 16'd137;   7'd37:  v = 16'd145;   7'd38:  v = 16'd154;   7'd39:  v = 16'd163;
            7'd40:  v = 16'd173;   7'd41:  v = 16'd183;   7'd42:  v = 16'd194;   7'd43:  v = 16'd206;
            7'd44:  v = 16'd218;   7'd45:  v = 16'd231;   7'd46:  v = 16'd244;   7'd47:  v = 16'd259;
            7'd48:  v = 16'd274;   7'd49:  v = 16'd291;   7'd50:  v = 16'd308;   7'd51:  v = 16'd326;
            7'd52:  v = 16'd346;   7'd53:  v = 16'd366;   7'd54:  v = 16'd388;   7'd55:  v = 16'd411;
            7'd56:  v = 16'd435;   7'd57:  v = 16'd461;   7'd58:  v = 16'd489;   7'd59:  v = 16'd518;
            7'd60:  v = 16'd549;   7'd61:  v = 16'd581;   7'd62:  v = 16'd616;   7'd63:  v = 16'd652;
            7'd64:  v = 16'd691;   7'd65:  v = 16'd732;   7'd66:  v = 16'd776;   7'd67:  v = 16'd822;
            7'd68:  v = 16'd871;   7'd69:  v = 16'd923;   7'd70:  v = 16'd978;   7'd71:  v = 16'd1036;
            7'd72:  v = 16'd1097;  7'd73:  v = 16'd1163;  7'd74:  v = 16'd1232;  7'd75:  v = 16'd1305;
            7'd76:  v = 16'd1383;  7'd77:  v = 16'd1465;  7'd78:  v = 16'd1552;  7'd79:  v = 16'd1644;
            7'd80:  v = 16'd1742;  7'd81:  v = 16'd1845;  7'd82:  v = 16'd1955;  7'd83:  v = 16'd2071;
            7'd84:  v = 16'd2195;  7'd85:  v = 16'd2325;  7'd86:  v = 16'd2463;  7'd87:  v = 16'd2610;
            7'd88:  v = 16'd2765;  7'd89:  v = 16'd2930;  7'd90:  v = 16'd3104;  7'd91:  v = 16'd3288;
            7'd92:  v = 16'd3484;  7'd93:  v = 16'd3691;  7'd94:  v = 16'd3910;  7'd95:  v = 16'd4143;
            7'd96:  v = 16'd4389;  7'd97:  v = 16'd4650;  7'd98:  v = 16'd4927;  7'd99:  v = 16'd5220;
            7'd100: v = 16'd5530;  7'd101: v = 16'd5859;  7'd102: v = 16'd6207;  7'd103: v = 16'd6577;
            7'd104: v = 16'd6968;  7'd105: v = 16'd7382;  7'd106: v = 16'd7821;  7'd107: v = 16'd8286;
            7'd108: v = 16'd8779;  7'd109: v = 16'd9301;  7'd110: v = 16'd9854;  7'd111: v = 16'd10440;
            7'd112: v = 16'd11060; 7'd113: v = 16'd11718; 7'd114: v = 16'd12415; 7'd115: v = 16'd13153;
            7'd116: v = 16'd13935; 7'd117: v = 16'd14764; 7'd118: v = 16'd15642; 7'd119: v = 16'd16572;
            7'd120: v = 16'd17557; 7'd121: v = 16'd18601; 7'd122: v = 16'd19708; 7'd123: v = 16'd20879;
            7'd124: v = 16'd22121; 7'd125: v = 16'd23436; 7'd126: v = 16'd24830;
            // note 127 is the only address left for the default arm
            default: v = 16'd26306;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk_i) begin
        data_a_q <= note_inc(addr_a_i);
        data_b_q <= note_inc(addr_b_i);
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/increment_to_midi_note.sv
// Converts a phase-accumulator increment to the nearest MIDI note by a
// 7-step binary search over the note table plus one neighbour comparison.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; latches increment, clears candidate
// ADDR     | present candidate|(1<<bit) to the ROM
// CMP      | keep the probed bit if table <= increment, step to next bit
// NADDR    | present floor note n and min(n+1,127) to the two ROM ports
// NCMP     | pick nearest of n / n+1, compute residual and flags
// DONE     | results valid, done pulses for one cycle
module increment_to_midi_note
    import audio_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [INC_W-1:0]  increment_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [NOTE_W-1:0] midi_note_o,
    output logic [INC_W-1:0]  residual_o,
    output logic              sharp_o,
    output logic              underflow_o,
    output logic              overflow_o
);

    inc2note_state_e   state_q;
    logic [INC_W-1:0]  inc_q;
    logic [NOTE_W-1:0] cand_q;
    logic [2:0]        bit_q;
    logic              busy_q;
    logic              done_q;
    logic [NOTE_W-1:0] note_q;
    logic [INC_W-1:0]  residual_q;
    logic              sharp_q;
    logic              underflow_q;
    logic              overflow_q;

    logic [NOTE_W-1:0] probe_mask;
    logic [NOTE_W-1:0] rom_addr_a;
    logic [NOTE_W-1:0] rom_addr_b;
    logic [INC_W-1:0]  rom_data_a;
    logic [INC_W-1:0]  rom_data_b;

    logic [INC_W:0]    lo_diff;
    logic [INC_W:0]    up_diff;
    logic              lo_below;
    logic              up_below;
    logic [INC_W-1:0]  lo_abs;
    logic [INC_W-1:0]  up_abs;
    logic              above_lo;
    logic              pick_up;
    logic [NOTE_W-1:0] note_d;
    logic [INC_W-1:0]  residual_d;
    logic              sharp_d;
    logic              underflow_d;
    logic              overflow_d;

    midi_note_table_rom u_rom (
        .clk_i    (clk_i),
        .addr_a_i (rom_addr_a),
        .addr_b_i (rom_addr_b),
        .data_a_o (rom_data_a),
        .data_b_o (rom_data_b)
    );

    always_comb begin
        probe_mask = NOTE_W'(1) << bit_q;
        rom_addr_a = (state_q == ST_ADDR) ? (cand_q | probe_mask) : cand_q;
        rom_addr_b = (cand_q == NOTE_MAX) ? NOTE_MAX : cand_q + NOTE_W'(1);

        // Signed at INC_W+1 bits; the magnitude is taken only after the sign is known.
        lo_diff  = {1'b0, inc_q} - {1'b0, rom_data_a};
        up_diff  = {1'b0, rom_data_b} - {1'b0, inc_q};
        lo_below = lo_diff[INC_W];
        up_below = up_diff[INC_W];
        lo_abs   = lo_below ? (~lo_diff[INC_W-1:0] + INC_W'(1)) : lo_diff[INC_W-1:0];
        up_abs   = up_below ? (~up_diff[INC_W-1:0] + INC_W'(1)) : up_diff[INC_W-1:0];
        above_lo = !lo_below && (lo_diff[INC_W-1:0] != '0);

        pick_up     = (cand_q != NOTE_MAX) && (up_abs < lo_abs);
        note_d      = pick_up ? rom_addr_b : cand_q;
        residual_d  = pick_up ? up_abs : lo_abs;
        sharp_d     = pick_up ? up_below : above_lo;
        underflow_d = (cand_q == '0) && lo_below;
        overflow_d  = (cand_q == NOTE_MAX) && above_lo;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            inc_q       <= '0;
            cand_q      <= '0;
            bit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            note_q      <= '0;
            residual_q  <= '0;
            sharp_q     <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        inc_q   <= increment_i;
                        cand_q  <= '0;
                        bit_q   <= TOP_BIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: state_q <= ST_CMP;
                ST_CMP: begin
                    if (rom_data_a <= inc_q) begin
                        cand_q <= cand_q | probe_mask;
                    end
                    if (bit_q != 3'd0) begin
                        bit_q   <= bit_q - 3'd1;
                        state_q <= ST_ADDR;
                    end else begin
                        state_q <= ST_NADDR;
                    end
                end
                ST_NADDR: state_q <= ST_NCMP;
                ST_NCMP: begin
                    note_q      <= note_d;
                    residual_q  <= residual_d;
                    sharp_q     <= sharp_d;
                    underflow_q <= underflow_d;
                    overflow_q  <= overflow_d;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign midi_note_o = note_q;
    assign residual_o  = residual_q;
    assign sharp_o     = sharp_q;
    assign underflow_o = underflow_q;
    assign overflow_o  = overflow_q;

endmodule
